// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: EX-stage <-> multiply/divide issue bundle.
//
// Signals
//   Valid     EX stage holds a valid instruction
//   Op        decoded MD op of the EX instruction (MDSEL_W bits)
//   HiLoRead  EX instruction is mfhi/mflo
//   RsData    forwarded rs operand (32)
//   RtData    forwarded rt operand (32)
//   Flush     EX instruction is being killed this cycle
//   Stall     hold IF/ID/EX this cycle (combinational from the controller)
//   MDStart   registered Start pulse to the MD unit
//   MDSel     registered op to the MD unit
//   MDA/MDB   registered operands to the MD unit
//
// Modports
//   master : the EX stage side (drives the instruction, sees Stall/MD outputs)
//   slave  : the issue controller
interface md_issue_ctrl_if #(
  parameter int MDSEL_W = 3
);
  logic               Valid;
  logic [MDSEL_W-1:0] Op;
  logic               HiLoRead;
  logic [31:0]        RsData;
  logic [31:0]        RtData;
  logic               Flush;
  logic               Stall;
  logic               MDStart;
  logic [MDSEL_W-1:0] MDSel;
  logic [31:0]        MDA;
  logic [31:0]        MDB;

  modport master (
    output Valid, Op, HiLoRead, RsData, RtData, Flush,
    input  Stall, MDStart, MDSel, MDA, MDB
  );

  modport slave (
    input  Valid, Op, HiLoRead, RsData, RtData, Flush,
    output Stall, MDStart, MDSel, MDA, MDB
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage front end of the multiply/divide unit.
//
// Accepts mult/multu/div/divu/mthi/mtlo and mfhi/mflo from EX, drives the MD
// unit's Start/MDSel/A/B from registers, tracks MD occupancy with a private
// latency countdown (never looks at MD Busy, which already contains Start),
// and raises Stall for structural and HI/LO hazards.
//
// Ports
//   Clk         clock
//   Reset       synchronous, active-high reset
//   bus         md_issue_ctrl_if.slave (Valid/Op/HiLoRead/RsData/RtData/Flush
//               in, Stall/MDStart/MDSel/MDA/MDB out)
//   StallCount  saturating count of stalled cycles (32)
//   DbgCnt      current occupancy countdown value, for observation
//
// Build option
//   MD_STALL_CNT_EN  when defined, StallCount counts edges with Stall=1 and
//                    saturates at 32'hFFFFFFFF; otherwise it is tied to 0.
//
// Handshake: an EX instruction is taken by this block in the cycle where
// Valid=1, Flush=0 and Stall=0; while Stall=1 EX must hold Valid/Op/operands
// unchanged. Flush withdraws the instruction in the same cycle without
// affecting anything already registered.
module md_issue_ctrl #(
  parameter int MDSEL_W  = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  md_issue_ctrl_if.slave     bus,
  output logic [31:0]        StallCount,
  output logic [CNT_W-1:0]   DbgCnt
);

  // MD op codes, mirroring the MDSEL_* codes of head.v; any other value
  // (including 0) means "no MD op".
  localparam logic [MDSEL_W-1:0] SEL_MULT  = MDSEL_W'(1);
  localparam logic [MDSEL_W-1:0] SEL_MULTU = MDSEL_W'(2);
  localparam logic [MDSEL_W-1:0] SEL_DIV   = MDSEL_W'(3);
  localparam logic [MDSEL_W-1:0] SEL_DIVU  = MDSEL_W'(4);
  localparam logic [MDSEL_W-1:0] SEL_MTHI  = MDSEL_W'(5);
  localparam logic [MDSEL_W-1:0] SEL_MTLO  = MDSEL_W'(6);

  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  logic [CNT_W-1:0]   cnt;
  logic               md_start_q;
  logic [MDSEL_W-1:0] md_sel_q;
  logic [31:0]        md_a_q;
  logic [31:0]        md_b_q;

  logic op_is_long;
  logic op_is_md;
  logic sel_is_mult;
  logic sel_is_div;
  logic block_issue;
  logic block_read;
  logic live;
  logic stall;
  logic accept;

  always_comb begin
    op_is_long  = (bus.Op == SEL_MULT) || (bus.Op == SEL_MULTU) ||
                  (bus.Op == SEL_DIV)  || (bus.Op == SEL_DIVU);
    op_is_md    = op_is_long || (bus.Op == SEL_MTHI) || (bus.Op == SEL_MTLO);
    sel_is_mult = (md_sel_q == SEL_MULT) || (md_sel_q == SEL_MULTU);
    sel_is_div  = (md_sel_q == SEL_DIV)  || (md_sel_q == SEL_DIVU);

    // A new op may issue when cnt==1: its Start lands as MD goes idle.
    // A long Start sitting in the register has not loaded cnt yet, so it
    // blocks on its own.
    block_issue = (cnt > CNT_ONE) || (md_start_q && (sel_is_mult || sel_is_div));
    // HI/LO reads wait for every outstanding write, including mthi/mtlo.
    block_read  = (cnt != CNT_ZERO) || md_start_q;

    live   = bus.Valid && !bus.Flush;
    stall  = live && ((op_is_md && block_issue) || (bus.HiLoRead && block_read));
    accept = live && op_is_md && !block_issue;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      md_start_q <= 1'b0;
      md_sel_q   <= '0;
      md_a_q     <= '0;
      md_b_q     <= '0;
      cnt        <= '0;
    end else begin
      md_start_q <= accept;
      if (accept) begin
        md_sel_q <= bus.Op;
        md_a_q   <= bus.RsData;
        md_b_q   <= bus.RtData;
      end

      if (md_start_q && sel_is_mult) begin
        cnt <= MULT_LAT_C;
      end else if (md_start_q && sel_is_div) begin
        cnt <= DIV_LAT_C;
      end else if (cnt != CNT_ZERO) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign bus.Stall   = stall;
  assign bus.MDStart = md_start_q;
  assign bus.MDSel   = md_sel_q;
  assign bus.MDA     = md_a_q;
  assign bus.MDB     = md_b_q;
  assign DbgCnt      = cnt;

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign StallCount = stall_count_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule
